axi4_lite_read_arbiter: RTL

Parametrised AXI4-lite read path that arbitrates between N_PORTS host requesters and serves one read at a time from the memory port. Internally an AXI4-lite read master drives a read slave over AR/R channels; the slave performs the memory-side Read_SIGNAL/DATA_ARRIVE handshake. Adds round-robin arbitration, configurable widths and an optional memory timeout with error response.

---
 rtl/axi4_lite_pkg.sv | 20 ++
 rtl/axi4_lite_read_mem_slave.sv | 110 +++++++++++
 rtl/axi4_lite_read_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared response codes and FSM state types for the AXI4-lite read arbiter.
package axi4_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      M_IDLE,
      M_AR,
      M_R,
      M_DONE
   } master_state_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEM,
      S_RESP
   } slave_state_t;

endpackage

// File: rtl/axi4_lite_read_mem_slave.sv
// AXI4-lite read slave bridging AR/R to the memory Read_SIGNAL/DATA_ARRIVE handshake.
// Optional memory timeout with SLVERR response when AXI4_RD_TIMEOUT_EN is defined.
//
// state  | meaning
// S_IDLE | ready for an AR transfer
// S_MEM  | memory strobe asserted, waiting for DATA_ARRIVE (or timeout)
// S_RESP | R_VALID asserted with latched data/response
module axi4_lite_read_mem_slave
   import axi4_lite_pkg::*;
#(
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 64,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ar_valid,
   input  logic [ADDR_W-1:0] ar_addr,
   output logic              ar_ready,
   output logic              r_valid,
   output logic [DATA_W-1:0] r_data,
   output logic [1:0]        r_resp,
   input  logic              r_ready,
   output logic              read_signal,
   output logic [ADDR_W-1:0] read_address,
   input  logic              data_arrive,
   input  logic [DATA_W-1:0] data_outside
);

   slave_state_t      s_state, s_state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [1:0]        resp_q;

`ifdef AXI4_RD_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] tmo_cnt;
   logic             tmo_done;

   // Down-counter loaded on S_MEM entry; terminal count marks the last wait cycle.
   assign tmo_done = (tmo_cnt == '0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_state <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         resp_q  <= RESP_OKAY;
`ifdef AXI4_RD_TIMEOUT_EN
         tmo_cnt <= '0;
`endif
      end else begin
         s_state <= s_state_nxt;
         if (s_state == S_IDLE && ar_valid) begin
            addr_q  <= ar_addr;
`ifdef AXI4_RD_TIMEOUT_EN
            tmo_cnt <= CNT_LOAD;
`endif
         end
         if (s_state == S_MEM) begin
            if (data_arrive) begin
               data_q <= data_outside;
               resp_q <= RESP_OKAY;
            end
`ifdef AXI4_RD_TIMEOUT_EN
            else if (tmo_done) begin
               data_q <= '0;
               resp_q <= RESP_SLVERR;
            end else begin
               tmo_cnt <= tmo_cnt - 1'b1;
            end
`endif
         end
      end
   end

   always_comb begin
      s_state_nxt = s_state;
      ar_ready    = 1'b0;
      read_signal = 1'b0;
      r_valid     = 1'b0;
      case (s_state)
         S_IDLE: begin
            ar_ready = 1'b1;
            if (ar_valid) s_state_nxt = S_MEM;
         end
         S_MEM: begin
            read_signal = 1'b1;
`ifdef AXI4_RD_TIMEOUT_EN
            if (data_arrive || tmo_done) s_state_nxt = S_RESP;
`else
            if (data_arrive) s_state_nxt = S_RESP;
`endif
         end
         S_RESP: begin
            r_valid = 1'b1;
            if (r_ready) s_state_nxt = S_IDLE;
         end
         default: s_state_nxt = S_IDLE;
      endcase
   end

   assign read_address = addr_q;
   assign r_data       = data_q;
   assign r_resp       = resp_q;

endmodule

// File: rtl/axi4_lite_read_arbiter.sv
// Round-robin arbiter plus AXI4-lite read master serving N_PORTS hosts, one read at a time.
// Optional memory timeout (AXI4_RD_TIMEOUT_EN) surfaces SLVERR as R_Error.
//
// state  | meaning
// M_IDLE | arbitrate among requesting ports
// M_AR   | AR_VALID with latched address of granted port
// M_R    | R_READY, waiting for R_VALID
// M_DONE | R_Finish pulse to granted port
module axi4_lite_read_arbiter
   import axi4_lite_pkg::*;
#(
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 64,
   parameter int N_PORTS     = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [N_PORTS*ADDR_W-1:0] R_Addr,
   input  logic [N_PORTS-1:0]        R_Request,
   output logic [N_PORTS-1:0]        R_Finish,
   output logic [N_PORTS-1:0]        R_Error,
   output logic [DATA_W-1:0]         Data_Out,
   output logic                      Read_SIGNAL,
   output logic [ADDR_W-1:0]         Read_ADDRESS,
   input  logic                      DATA_ARRIVE,
   input  logic [DATA_W-1:0]         DATA_OUTSIDE
);

   localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_PORTS - 1);

   master_state_t     m_state, m_state_nxt;
   logic [IDX_W-1:0]  last_grant, pick;
   logic              req_any;
   int                idx;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              ar_valid, ar_ready, r_valid, r_ready;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        r_resp;

   // Scan downward so the port closest after last_grant is the final (winning) assignment.
   always_comb begin
      req_any = 1'b0;
      pick    = last_grant;
      idx     = 0;
      for (int k = N_PORTS; k >= 1; k--) begin
         idx = int'(last_grant) + k;
         if (idx >= N_PORTS) idx = idx - N_PORTS;
         if (R_Request[idx]) begin
            req_any = 1'b1;
            pick    = IDX_W'(idx);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_state    <= M_IDLE;
         last_grant <= LAST_RST;
         addr_q     <= '0;
         data_q     <= '0;
      end else begin
         m_state <= m_state_nxt;
         if (m_state == M_IDLE && req_any) begin
            last_grant <= pick;
            addr_q     <= R_Addr[int'(pick)*ADDR_W +: ADDR_W];
         end
         if (m_state == M_R && r_valid) data_q <= r_data;
      end
   end

   always_comb begin
      m_state_nxt = m_state;
      ar_valid    = 1'b0;
      r_ready     = 1'b0;
      case (m_state)
         M_IDLE: if (req_any) m_state_nxt = M_AR;
         M_AR: begin
            ar_valid = 1'b1;
            if (ar_ready) m_state_nxt = M_R;
         end
         M_R: begin
            r_ready = 1'b1;
            if (r_valid) m_state_nxt = M_DONE;
         end
         M_DONE:  m_state_nxt = M_IDLE;
         default: m_state_nxt = M_IDLE;
      endcase
   end

   always_comb begin
      R_Finish = '0;
      for (int i = 0; i < N_PORTS; i++)
         R_Finish[i] = (m_state == M_DONE) && (int'(last_grant) == i);
   end

`ifdef AXI4_RD_TIMEOUT_EN
   logic err_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                          err_q <= 1'b0;
      else if (m_state == M_R && r_valid) err_q <= (r_resp == RESP_SLVERR);
   end

   assign R_Error = R_Finish & {N_PORTS{err_q}};
`else
   assign R_Error = '0;
`endif

   assign Data_Out = data_q;

   axi4_lite_read_mem_slave #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_slave (
      .clk          (CLK),
      .rst          (RST),
      .ar_valid     (ar_valid),
      .ar_addr      (addr_q),
      .ar_ready     (ar_ready),
      .r_valid      (r_valid),
      .r_data       (r_data),
      .r_resp       (r_resp),
      .r_ready      (r_ready),
      .read_signal  (Read_SIGNAL),
      .read_address (Read_ADDRESS),
      .data_arrive  (DATA_ARRIVE),
      .data_outside (DATA_OUTSIDE)
   );

endmodule
